// File: rtl/stall_controller.sv
// ---------------------------------------------------------------------------
// stall_controller
//
// Pipeline stall/flush sequencer sitting between the hazard unit and the
// IF/ID, ID/EX and PC registers. The enable/flush/bubble outputs are Mealy:
// they are decoded from the current state and the live hazard inputs, so a
// stall or flush acts in the same cycle the request appears.
//
// Ports
//   Clk          in   pipeline clock, rising edge
//   Rst_n        in   asynchronous active-low reset
//   FlushSignal  in   operand dependency in decode; insert a nop
//   BranchTaken  in   decode-stage branch/jump resolved taken
//   PCWrite      out  PC load enable
//   IF_ID_Write  out  IF/ID load enable
//   IF_ID_Flush  out  IF/ID loads a nop on this edge
//   ID_EX_Bubble out  ID/EX loads zeroed control on this edge
//   StallState   out  current state (RUN=00, STALL=01, FLUSH=10, HALT=11)
//   StallLen     out  consecutive stall cycles taken, saturating at 3
//   StallError   out  sticky: a stall ran past 3 cycles
//   StallCount   out  [STALL_PERF_COUNTERS_EN] bubbles inserted outside HALT
//   FlushCount   out  [STALL_PERF_COUNTERS_EN] IF/ID flushes issued
//
// Build option: define STALL_PERF_COUNTERS_EN to add the two 32-bit
// wrapping performance counters and their ports.
//
// state  | meaning
// RUN    | normal flow, PC and IF/ID advance
// STALL  | dependency stall in progress, StallLen counts its cycles
// FLUSH  | IF/ID holds a squashed slot; its branch indication is ignored
// HALT   | stall ran too long; pipeline frozen until reset
// ---------------------------------------------------------------------------
module stall_controller (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        FlushSignal,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic [1:0]  StallState,
    output logic [1:0]  StallLen,
    output logic        StallError
`ifdef STALL_PERF_COUNTERS_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] len_q, len_d;
    logic       err_q, err_d;

    logic pc_w, ifid_w, ifid_f, idex_b;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        err_d   = err_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        ifid_f  = 1'b0;
        idex_b  = 1'b0;

        if (state_q == ST_HALT) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_b = 1'b1;
        end else if (FlushSignal) begin
            // Dependency wins over a taken branch: branch operands are stale.
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_b = 1'b1;
            if (state_q == ST_STALL) begin
                if (len_q == 2'd3) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    len_d = len_q + 2'd1;
                end
            end else begin
                state_d = ST_STALL;
                len_d   = 2'd1;
            end
        end else begin
            len_d = 2'd0;
            // In FLUSH the decode slot is a nop, so its branch flag is bogus.
            if (BranchTaken && (state_q != ST_FLUSH)) begin
                ifid_f  = 1'b1;
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_RUN;
            len_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Reset forces the pipeline into a safe frozen/squashed posture
    // immediately, without waiting for a clock.
    assign PCWrite      = Rst_n & pc_w;
    assign IF_ID_Write  = Rst_n & ifid_w;
    assign IF_ID_Flush  = ~Rst_n | ifid_f;
    assign ID_EX_Bubble = ~Rst_n | idex_b;
    assign StallState   = state_q;
    assign StallLen     = len_q;
    assign StallError   = err_q;

`ifdef STALL_PERF_COUNTERS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (idex_b && (state_q != ST_HALT))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ifid_f)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 SHALL have port Clk, input, 1, pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port FlushSignal, input, 1, hazard-unit request: 1 = decode operand dependency, insert nop.
REQ-004 SHALL have port BranchTaken, input, 1, decode-stage branch/jump resolved taken; meaningful only when FlushSignal=0.
REQ-005 SHALL have port PCWrite, output, 1, PC register load enable.
REQ-006 SHALL have port IF_ID_Write, output, 1, IF/ID register load enable.
REQ-007 SHALL have port IF_ID_Flush, output, 1, IF/ID register loads nop on this edge.
REQ-008 SHALL have port ID_EX_Bubble, output, 1, ID/EX loads zeroed control signals on this edge.
REQ-009 SHALL have port StallState, output, 2, current state (RUN=00, STALL=01, FLUSH=10, HALT=11).
REQ-010 SHALL have port StallLen, output, 2, consecutive stall cycles already taken, saturating at 3.
REQ-011 SHALL have port StallError, output, 1, sticky flag: stall exceeded 3 cycles.

Function
REQ-012 SHALL implement a four-state FSM (RUN, STALL, FLUSH, HALT) with Mealy outputs, so a stall takes effect in the same cycle FlushSignal rises.
REQ-013 RUN, FlushSignal=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0; next state STALL; StallLen becomes 1.
REQ-014 RUN, FlushSignal=0, BranchTaken=1: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=0; next state FLUSH.
REQ-015 RUN, both inputs 0: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0; stay in RUN.
REQ-016 FlushSignal=1 SHALL take priority over BranchTaken in every state, because branch operands are not yet valid.
REQ-017 STALL, FlushSignal=1, StallLen<3: outputs as in REQ-013; StallLen increments; stay in STALL.
REQ-018 STALL, FlushSignal=1, StallLen=3: outputs as in REQ-013; next state HALT; StallError set on the same edge.
REQ-019 STALL, FlushSignal=0: outputs as in RUN with the same BranchTaken handling; next state FLUSH if BranchTaken=1, else RUN; StallLen cleared.
REQ-020 FLUSH lasts exactly one cycle.
- BranchTaken is ignored, because IF/ID holds a nop.
- FlushSignal is handled as in RUN (next state STALL if set).
- Otherwise outputs are as in REQ-015 and the next state is RUN.
REQ-021 HALT: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, regardless of inputs; only reset exits HALT.
REQ-022 StallError SHALL stay 1 until reset; StallLen SHALL never wrap past 3.

Reset
REQ-023 While Rst_n=0, the block SHALL hold the following values, independent of Clk:
- state RUN, StallLen=0, StallError=0;
- PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1.
REQ-024 Reset asserted mid-stall or in HALT SHALL return the FSM to RUN; the first edge after Rst_n rises evaluates the inputs per REQ-013..015.

Configuration
REQ-025 Macro STALL_PERF_COUNTERS_EN defined: the block SHALL add outputs StallCount[31:0] and FlushCount[31:0].
- StallCount increments on every edge where ID_EX_Bubble=1 outside HALT.
- FlushCount increments on every edge where IF_ID_Flush=1 outside reset.
- Both counters wrap modulo 2^32 and reset to 0.
REQ-026 Macro STALL_PERF_COUNTERS_EN undefined: the block SHALL have neither port nor counter logic; all other behaviour is identical.

Verification
REQ-027 Reset, then FlushSignal=0, BranchTaken=0 for 5 cycles -> PCWrite=1 and IF_ID_Write=1 every cycle, StallState=00.
REQ-028 FlushSignal=1 for 2 cycles, then 0 -> cycles 1-2: PCWrite=0, ID_EX_Bubble=1, StallLen 1 then 2; cycle 3: RUN, StallLen=0.
REQ-029 FlushSignal=1 and BranchTaken=1 together for 1 cycle, then BranchTaken=1 alone -> first cycle: stall with no flush; second cycle: IF_ID_Flush=1, then state FLUSH.
REQ-030 BranchTaken=1 for 2 consecutive cycles -> the first asserts IF_ID_Flush; the second (FLUSH state) is ignored with IF_ID_Flush=0, then state RUN.
REQ-031 FlushSignal=1 for 5 cycles -> StallError=1 after the 4th edge; state HALT; outputs frozen; Rst_n pulse low clears to RUN with StallError=0.
REQ-032 With STALL_PERF_COUNTERS_EN, run the REQ-028 stimulus followed by one taken branch -> StallCount=2, FlushCount=1.
